// File: rtl/mcc_multiword_seq_pkg.sv
// mcc_multiword_seq_pkg: shared slice width and sequencer state encodings
package mcc_multiword_seq_pkg;
  localparam int SLICE_W = 5;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/mcc_multiword_seq_adder.sv
// mcc_multiword_seq_adder: registered 5-bit Manchester-carry-chain adder (input and output dffs, no reset)
import mcc_multiword_seq_pkg::*;
module mcc_multiword_seq_adder (
  input  logic               clk,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W-1:0] a_r, b_r, g, p;
  logic [SLICE_W:0]   c;
  logic               cin_r;
  assign g = a_r & b_r;
  assign p = a_r ^ b_r;
  assign c[0] = cin_r;
  for (genvar i = 0; i < SLICE_W; i++) begin : g_chain
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end
  always_ff @(posedge clk) begin
    a_r   <= a;
    b_r   <= b;
    cin_r <= cin;
    sum   <= p ^ c[SLICE_W-1:0];
    cout  <= c[SLICE_W];
  end
endmodule

// File: rtl/mcc_multiword_seq.sv
// mcc_multiword_seq: wide add by sequencing one registered 5-bit adder slice by slice, LSB first
import mcc_multiword_seq_pkg::*;
module mcc_multiword_seq #(
  parameter int WORDS   = 4,
  parameter int ADD_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORDS*SLICE_W-1:0]   op_a,
  input  logic [WORDS*SLICE_W-1:0]   op_b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [WORDS*SLICE_W-1:0]   result,
  output logic                       cout,
  output logic                       ovf,
  output logic [SLICE_W-1:0]         add_a,
  output logic [SLICE_W-1:0]         add_b,
  output logic                       add_cin,
  input  logic [SLICE_W-1:0]         add_sum,
  input  logic                       add_cout
);
  localparam int W  = WORDS * SLICE_W;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(ADD_LAT + 1);
  logic [1:0]    state;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          last;
  assign last    = idx == IW'(WORDS - 1);
  assign busy    = state == ST_ISSUE || state == ST_WAIT;
  assign done    = state == ST_DONE;
  assign add_a   = busy ? a_q[idx*SLICE_W +: SLICE_W] : '0;
  assign add_b   = busy ? b_q[idx*SLICE_W +: SLICE_W] : '0;
  assign add_cin = busy & carry;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          carry <= cin;
          idx   <= '0;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt   <= CW'(ADD_LAT);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          // the registered sum is only trusted once the full adder latency has elapsed
          if (cnt == CW'(1)) begin
            result[idx*SLICE_W +: SLICE_W] <= add_sum;
            carry <= add_cout;
            if (last) begin
              cout  <= add_cout;
              ovf   <= (a_q[W-1] == b_q[W-1]) && (add_sum[SLICE_W-1] != a_q[W-1]);
              state <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_ISSUE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
